// File: rtl/au_seq_pkg.sv
// rtl/au_seq_pkg.sv - op encodings, FSM states and condition-code indices for au_seq_nbit
package au_seq_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_ADC = 3'b010;
    localparam logic [2:0] OP_SBB = 3'b011;
    localparam logic [2:0] OP_CMP = 3'b100;
    localparam logic [2:0] OP_NEG = 3'b101;
    localparam logic [2:0] OP_MUL = 3'b110;
    localparam logic [2:0] OP_ILL = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        MUL  = 2'd2
    } state_t;

    localparam int CC_Z   = 0;
    localparam int CC_C   = 1;
    localparam int CC_NEG = 2;
    localparam int CC_OV  = 3;

    // Opcode 110 is only accepted when the multiplier is built in.
    function automatic logic op_legal(input logic [2:0] op);
`ifdef AU_SEQ_MUL_EN
        return (op != OP_ILL);
`else
        return (op <= OP_NEG);
`endif
    endfunction

endpackage

// File: rtl/au_addsub.sv
// rtl/au_addsub.sv - combinational A +/- B with carry-in, carry-out and carry into the MSB
module au_addsub #(
    parameter int W = 8
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic         sub_i,
    input  logic         cin_i,
    output logic [W-1:0] s_o,
    output logic         cout_o,
    output logic         cmsb_o
);

    logic [W-1:0] bb;
    logic [W:0]   full;
    logic [W-1:0] low;

    // Subtraction is A + ~B + cin; the caller chooses cin (1 for plain SUB, C for SBB).
    always_comb begin
        bb   = sub_i ? ~b_i : b_i;
        full = {1'b0, a_i} + {1'b0, bb} + {{W{1'b0}}, cin_i};
        low  = {1'b0, a_i[W-2:0]} + {1'b0, bb[W-2:0]} + {{(W-1){1'b0}}, cin_i};
    end

    assign s_o    = full[W-1:0];
    assign cout_o = full[W];
    assign cmsb_o = low[W-1];

endmodule

// File: rtl/au_seq_nbit.sv
// rtl/au_seq_nbit.sv - registered N-bit arithmetic unit, optional multiplier under AU_SEQ_MUL_EN
module au_seq_nbit
    import au_seq_pkg::*;
#(
    parameter int W  = 8,
    parameter int CW = 4
) (
    input  logic          CLK,
    input  logic          CLR,
    input  logic [W-1:0]  X,
    input  logic          LdA,
    input  logic          LdB,
    input  logic [2:0]    Op,
    input  logic          Start,
    output logic          Busy,
    output logic          Done,
    output logic          Err,
    output logic [W-1:0]  Rout,
    output logic [W-1:0]  Rhi,
    output logic [CW-1:0] Ccout
);

    state_t         state_q;
    logic [W-1:0]   a_q, b_q;
    logic [W-1:0]   opa_q, opb_q;
    logic [2:0]     op_q;
    logic [W-1:0]   rout_q;
    logic [CW-1:0]  cc_q;
    logic           done_q, err_q;

    logic [W-1:0]   add_a, add_b, add_sum;
    logic           add_sub, add_cin, add_cout, add_cmsb;
    logic [CW-1:0]  cc_add_d;

`ifdef AU_SEQ_MUL_EN
    localparam int CNTW = (W > 1) ? $clog2(W) : 1;
    logic [W-1:0]   rhi_q;
    logic [W-1:0]   hi_q, lo_q;
    logic [CNTW-1:0] cnt_q;
    logic [W:0]     mul_ext;
    logic [W-1:0]   mul_hi_d, mul_lo_d;
    logic [CW-1:0]  cc_mul_d;
`endif

    // Adder operand select: the multiplier borrows the adder for partial sums.
    always_comb begin
        add_a   = opa_q;
        add_b   = opb_q;
        add_sub = 1'b0;
        add_cin = 1'b0;
        case (op_q)
            OP_SUB, OP_CMP: begin
                add_sub = 1'b1;
                add_cin = 1'b1;
            end
            OP_ADC: add_cin = cc_q[CC_C];
            OP_SBB: begin
                add_sub = 1'b1;
                add_cin = cc_q[CC_C];
            end
            OP_NEG: begin
                add_a   = '0;
                add_b   = opa_q;
                add_sub = 1'b1;
                add_cin = 1'b1;
            end
            default: ;
        endcase
`ifdef AU_SEQ_MUL_EN
        if (state_q == MUL) begin
            add_a   = hi_q;
            add_b   = opa_q;
            add_sub = 1'b0;
            add_cin = 1'b0;
        end
`endif
    end

    au_addsub #(.W(W)) u_addsub (
        .a_i    (add_a),
        .b_i    (add_b),
        .sub_i  (add_sub),
        .cin_i  (add_cin),
        .s_o    (add_sum),
        .cout_o (add_cout),
        .cmsb_o (add_cmsb)
    );

    // Condition codes for the add/subtract family.
    always_comb begin
        cc_add_d         = '0;
        cc_add_d[CC_Z]   = (add_sum == '0);
        cc_add_d[CC_C]   = add_cout;
        cc_add_d[CC_NEG] = add_sum[W-1];
        cc_add_d[CC_OV]  = add_cout ^ add_cmsb;
    end

`ifdef AU_SEQ_MUL_EN
    // One shift-add step: conditionally add the multiplicand into the high half, then shift right.
    always_comb begin
        mul_ext  = lo_q[0] ? {add_cout, add_sum} : {1'b0, hi_q};
        mul_hi_d = mul_ext[W:1];
        mul_lo_d = {mul_ext[0], lo_q[W-1:1]};
        cc_mul_d         = '0;
        cc_mul_d[CC_Z]   = ({mul_hi_d, mul_lo_d} == '0);
        cc_mul_d[CC_C]   = (mul_hi_d != '0);
        cc_mul_d[CC_OV]  = (mul_hi_d != '0);
    end
`endif

    // Control FSM with operand snapshot and registered results.
    always_ff @(posedge CLK) begin
        if (CLR) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            opa_q   <= '0;
            opb_q   <= '0;
            op_q    <= OP_ADD;
            rout_q  <= '0;
            cc_q    <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
`ifdef AU_SEQ_MUL_EN
            rhi_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            cnt_q   <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (LdA) a_q <= X;
                    if (LdB) b_q <= X;
                    if (Start) begin
                        if (op_legal(Op)) begin
                            // Snapshot the pre-load operands so a same-cycle load does not leak in.
                            err_q <= 1'b0;
                            op_q  <= Op;
                            opa_q <= a_q;
                            opb_q <= b_q;
`ifdef AU_SEQ_MUL_EN
                            if (Op == OP_MUL) begin
                                state_q <= MUL;
                                hi_q    <= '0;
                                lo_q    <= b_q;
                                cnt_q   <= '0;
                            end else begin
                                state_q <= EXEC;
                            end
`else
                            state_q <= EXEC;
`endif
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                EXEC: begin
                    state_q <= IDLE;
                    done_q  <= 1'b1;
                    cc_q    <= cc_add_d;
                    if (op_q != OP_CMP) begin
                        rout_q <= add_sum;
`ifdef AU_SEQ_MUL_EN
                        rhi_q  <= '0;
`endif
                    end
                end
`ifdef AU_SEQ_MUL_EN
                MUL: begin
                    hi_q  <= mul_hi_d;
                    lo_q  <= mul_lo_d;
                    cnt_q <= cnt_q + 1'b1;
                    // The last iteration latches the finished product directly.
                    if (cnt_q == CNTW'(W - 1)) begin
                        state_q <= IDLE;
                        done_q  <= 1'b1;
                        rout_q  <= mul_lo_d;
                        rhi_q   <= mul_hi_d;
                        cc_q    <= cc_mul_d;
                    end
                end
`endif
                default: state_q <= IDLE;
            endcase
        end
    end

    assign Busy  = (state_q != IDLE);
    assign Done  = done_q;
    assign Err   = err_q;
    assign Rout  = rout_q;
    assign Ccout = cc_q;
`ifdef AU_SEQ_MUL_EN
    assign Rhi   = rhi_q;
`else
    assign Rhi   = '0;
`endif

endmodule

// File: tb/tb_au_seq_nbit.sv
// tb/tb_au_seq_nbit.sv - vector table plus scoreboard bench for au_seq_nbit at W=8
module tb_au_seq_nbit;

    logic       CLK = 1'b0;
    logic       CLR = 1'b1;
    logic [7:0] X = '0;
    logic       LdA = 1'b0, LdB = 1'b0, Start = 1'b0;
    logic [2:0] Op = '0;
    logic       Busy, Done, Err;
    logic [7:0] Rout, Rhi;
    logic [3:0] Ccout;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [7:0] r;
        logic [7:0] rh;
        logic [3:0] cc;
        int         lat;
    } exp_t;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [2:0] op;
        logic       legal;
        logic [7:0] r;
        logic [7:0] rh;
        logic [3:0] cc;
        int         lat;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[15];

    au_seq_nbit #(.W(8), .CW(4)) dut (
        .CLK(CLK), .CLR(CLR), .X(X), .LdA(LdA), .LdB(LdB), .Op(Op), .Start(Start),
        .Busy(Busy), .Done(Done), .Err(Err), .Rout(Rout), .Rhi(Rhi), .Ccout(Ccout)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic load_ab(input logic [7:0] a, input logic [7:0] b);
        X = a; LdA = 1'b1; tick(); LdA = 1'b0;
        X = b; LdB = 1'b1; tick(); LdB = 1'b0;
    endtask

    // Called right after the Start edge; waits for Done and compares against the scoreboard.
    task automatic wait_result(input string tag);
        int   lat;
        exp_t e;
        lat = 1;
        @(negedge CLK);
        chk({tag, "_busy"}, Busy, 1);
        while (!Done && lat < 40) begin
            @(negedge CLK);
            lat++;
        end
        if (!Done) begin
            chk({tag, "_done_timeout"}, Done, 1);
            if (sb.size() > 0) void'(sb.pop_front());
        end else if (sb.size() == 0) begin
            chk({tag, "_unexpected_done"}, Done, 0);
        end else begin
            e = sb.pop_front();
            chk({tag, "_rout"},  Rout,  e.r);
            chk({tag, "_rhi"},   Rhi,   e.rh);
            chk({tag, "_cc"},    Ccout, e.cc);
            chk({tag, "_lat"},   lat,   e.lat);
            chk({tag, "_err"},   Err,   0);
        end
        @(negedge CLK);
        chk({tag, "_done_pulse"}, Done, 0);
    endtask

    task automatic run_op(input logic [2:0] op, input logic legal, input exp_t e, input string tag);
        bit seen;
        Op = op; Start = 1'b1;
        if (legal) sb.push_back(e);
        tick();
        Start = 1'b0;
        if (legal) begin
            wait_result(tag);
        end else begin
            seen = 0;
            repeat (4) begin
                @(negedge CLK);
                if (Done || Busy) seen = 1;
            end
            chk({tag, "_ill_quiet"}, seen, 0);
            chk({tag, "_ill_err"},   Err,  1);
            chk({tag, "_ill_rout"},  Rout, e.r);
        end
    endtask

    initial begin
        exp_t e;
        bit   seen;
        int   abort_dly;
        logic [2:0] abort_op;

        vecs[0]  = '{8'h7F, 8'h01, 3'b000, 1'b1, 8'h80, 8'h00, 4'b1100, 2};
        vecs[1]  = '{8'h05, 8'h05, 3'b001, 1'b1, 8'h00, 8'h00, 4'b0011, 2};
        vecs[2]  = '{8'hFF, 8'h01, 3'b000, 1'b1, 8'h00, 8'h00, 4'b0011, 2};
        vecs[3]  = '{8'h00, 8'h00, 3'b010, 1'b1, 8'h01, 8'h00, 4'b0000, 2};
        vecs[4]  = '{8'h03, 8'h04, 3'b100, 1'b1, 8'h01, 8'h00, 4'b0100, 2};
        vecs[5]  = '{8'h03, 8'h04, 3'b111, 1'b0, 8'h01, 8'h00, 4'b0000, 0};
        vecs[6]  = '{8'h0A, 8'h03, 3'b011, 1'b1, 8'h06, 8'h00, 4'b0010, 2};
        vecs[7]  = '{8'h0A, 8'h03, 3'b011, 1'b1, 8'h07, 8'h00, 4'b0010, 2};
        vecs[8]  = '{8'h01, 8'h55, 3'b101, 1'b1, 8'hFF, 8'h00, 4'b0100, 2};
        vecs[9]  = '{8'h80, 8'h00, 3'b101, 1'b1, 8'h80, 8'h00, 4'b1100, 2};
        vecs[10] = '{8'h00, 8'h00, 3'b101, 1'b1, 8'h00, 8'h00, 4'b0011, 2};
        vecs[11] = '{8'h80, 8'h01, 3'b001, 1'b1, 8'h7F, 8'h00, 4'b1010, 2};
`ifdef AU_SEQ_MUL_EN
        vecs[12] = '{8'hFF, 8'hFF, 3'b110, 1'b1, 8'h01, 8'hFE, 4'b1010, 9};
        vecs[13] = '{8'h00, 8'h37, 3'b110, 1'b1, 8'h00, 8'h00, 4'b0001, 9};
`else
        vecs[12] = '{8'hFF, 8'hFF, 3'b110, 1'b0, 8'h7F, 8'h00, 4'b0000, 0};
        vecs[13] = '{8'h00, 8'h37, 3'b110, 1'b0, 8'h7F, 8'h00, 4'b0000, 0};
`endif
        vecs[14] = '{8'h12, 8'h34, 3'b000, 1'b1, 8'h46, 8'h00, 4'b0000, 2};

        tick(); tick();
        CLR = 1'b0;
        @(negedge CLK);
        chk("rst_rout", Rout, 0);
        chk("rst_rhi",  Rhi,  0);
        chk("rst_cc",   Ccout, 0);
        chk("rst_busy", Busy, 0);
        chk("rst_done", Done, 0);
        chk("rst_err",  Err,  0);

        for (int i = 0; i < 15; i++) begin
            load_ab(vecs[i].a, vecs[i].b);
            e = '{vecs[i].r, vecs[i].rh, vecs[i].cc, vecs[i].lat};
            run_op(vecs[i].op, vecs[i].legal, e, $sformatf("vec%0d", i));
        end

        // Start together with LdA: the op sees the old A, the load still lands.
        load_ab(8'h10, 8'h20);
        X = 8'h99; LdA = 1'b1; Op = 3'b000; Start = 1'b1;
        sb.push_back('{8'h30, 8'h00, 4'b0000, 2});
        tick();
        LdA = 1'b0; Start = 1'b0;
        wait_result("ldstart");
        run_op(3'b000, 1'b1, '{8'hB9, 8'h00, 4'b0100, 2}, "ldstart_after");

        // LdA and LdB together load the same bus value.
        X = 8'h21; LdA = 1'b1; LdB = 1'b1; tick(); LdA = 1'b0; LdB = 1'b0;
        run_op(3'b000, 1'b1, '{8'h42, 8'h00, 4'b0000, 2}, "ldboth");

        // Loads and a second Start while Busy are ignored.
        load_ab(8'h05, 8'h06);
        Op = 3'b000; Start = 1'b1; tick();
        X = 8'hEE; LdA = 1'b1; LdB = 1'b1; Op = 3'b001; tick();
        LdA = 1'b0; LdB = 1'b0; Start = 1'b0;
        @(negedge CLK);
        chk("busyld_done", Done, 1);
        chk("busyld_rout", Rout, 8'h0B);
        @(negedge CLK);
        chk("busyld_nostart", Busy | Done, 0);
        run_op(3'b000, 1'b1, '{8'h0B, 8'h00, 4'b0000, 2}, "busyld_frozen");

        // CLR mid-operation aborts with no Done and clears everything.
`ifdef AU_SEQ_MUL_EN
        abort_op = 3'b110; abort_dly = 2;
`else
        abort_op = 3'b000; abort_dly = 0;
`endif
        load_ab(8'hFF, 8'hFF);
        run_op(3'b111, 1'b0, '{8'h0B, 8'h00, 4'b0000, 0}, "pre_abort_ill");
        Op = abort_op; Start = 1'b1; tick(); Start = 1'b0;
        repeat (abort_dly) tick();
        CLR = 1'b1; tick(); CLR = 1'b0;
        @(negedge CLK);
        chk("abort_rout", Rout, 0);
        chk("abort_rhi",  Rhi,  0);
        chk("abort_cc",   Ccout, 0);
        chk("abort_busy", Busy, 0);
        chk("abort_err",  Err,  0);
        seen = 0;
        repeat (12) begin
            @(negedge CLK);
            if (Done || Busy) seen = 1;
        end
        chk("abort_nodone", seen, 0);
        run_op(3'b000, 1'b1, '{8'h00, 8'h00, 4'b0001, 2}, "abort_ab_zero");

        chk("sb_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
